// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets two requesters share
// one combinational ALU, one transaction in flight at a time.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_* / req1_*          request channels (valid/ready, a, b, op)
//   rsp0_* / rsp1_*          response channels (valid/ready)
//   rsp_f, rsp_zf, rsp_of    captured ALU result, shared by both responses
//   alu_a, alu_b, alu_op     drive the shared ALU inputs
//   alu_f, alu_zf, alu_of    ALU outputs, sampled at the end of EXEC
//   busy                     high while a transaction is in EXEC or RESP
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_f,
    output logic              rsp_zf,
    output logic              rsp_of,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;

    // ptr names the requester favoured on contention; gnt remembers
    // which requester owns the transaction currently in flight.
    logic ptr;
    logic gnt;

    logic win0;
    logic win1;
    logic acc0;
    logic acc1;
    logic rsp_done;

    // A lone valid wins outright; the pointer only breaks ties.
    always_comb begin
        win0 = req0_valid && (!req1_valid || !ptr);
        win1 = req1_valid && (!req0_valid || ptr);
    end

    // Ready is gated by rst so nothing looks accepted while in reset.
    always_comb begin
        req0_ready = !rst && (state == IDLE) && win0;
        req1_ready = !rst && (state == IDLE) && win1;
    end

    always_comb begin
        acc0 = req0_ready && req0_valid;
        acc1 = req1_ready && req1_valid;
    end

    always_comb begin
        rsp_done = (rsp0_valid && rsp0_ready) ||
                   (rsp1_valid && rsp1_ready);
    end

    // The operand registers are the alu_* outputs themselves, so the
    // ALU inputs stay stable through EXEC and keep their value in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            gnt        <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_f      <= '0;
            rsp_zf     <= 1'b0;
            rsp_of     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        acc0: begin
                            alu_a  <= req0_a;
                            alu_b  <= req0_b;
                            alu_op <= req0_op;
                            gnt    <= 1'b0;
                            state  <= EXEC;
                            busy   <= 1'b1;
                        end
                        acc1: begin
                            alu_a  <= req1_a;
                            alu_b  <= req1_b;
                            alu_op <= req1_op;
                            gnt    <= 1'b1;
                            state  <= EXEC;
                            busy   <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end

                // Single-cycle combinational ALU path: sample it here.
                EXEC: begin
                    rsp_f      <= alu_f;
                    rsp_zf     <= alu_zf;
                    rsp_of     <= alu_of;
                    rsp0_valid <= !gnt;
                    rsp1_valid <= gnt;
                    state      <= RESP;
                end

                // Result is held until the owner takes it.
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        ptr        <= !gnt;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
